// File: rtl/ddr3_port_arbiter.sv
// Round-robin arbiter sharing one DDR3 MIG app port among NUM_CH memory clients.
// One command in flight at a time; read data is steered back to the granted channel.
module ddr3_port_arbiter #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned ADDR_W      = 27,
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         calib_done,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH-1:0]            ch_we,
    input  logic [NUM_CH*ADDR_W-1:0]     ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]     ch_wdata,
    input  logic [NUM_CH*(DATA_W/8)-1:0] ch_wmask,
    output logic [NUM_CH-1:0]            ch_ack,
    output logic [NUM_CH-1:0]            ch_rvalid,
    output logic [DATA_W-1:0]            ch_rdata,
    output logic [ADDR_W-1:0]            app_addr,
    output logic [2:0]                   app_cmd,
    output logic                         app_en,
    input  logic                         app_rdy,
    output logic [DATA_W-1:0]            app_wdf_data,
    output logic [DATA_W/8-1:0]          app_wdf_mask,
    output logic                         app_wdf_wren,
    output logic                         app_wdf_end,
    input  logic                         app_wdf_rdy,
    input  logic [DATA_W-1:0]            app_rd_data,
    input  logic                         app_rd_data_valid,
    output logic                         busy,
    output logic [$clog2(NUM_CH)-1:0]    grant_id,
    output logic                         err_timeout
);
    localparam int unsigned GW = $clog2(NUM_CH);
    localparam int unsigned MW = DATA_W / 8;
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [1:0] {IDLE, CMD, RWAIT, ACK} state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      last_grant_q, last_grant_d;
    logic [GW-1:0]      grant_id_q, grant_id_d;
    logic [GW-1:0]      gsel;
    logic               found;
    int unsigned        idx;
    logic               we_q, we_d;
    logic               cmd_done_q, cmd_done_d, cmd_now;
    logic               wdf_done_q, wdf_done_d, wdf_now;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [NUM_CH-1:0]  ack_q, ack_d;
    logic [NUM_CH-1:0]  rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [2:0]         cmd_q, cmd_d;
    logic               en_q, en_d;
    logic               wren_q, wren_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [MW-1:0]      wmask_q, wmask_d;

    // Next-state, arbitration and registered-output computation.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        we_d         = we_q;
        cmd_done_d   = cmd_done_q;
        wdf_done_d   = wdf_done_q;
        cnt_d        = '0;
        err_d        = err_q;
        rdata_d      = rdata_q;
        ack_d        = '0;
        rvalid_d     = '0;
        addr_d       = '0;
        cmd_d        = '0;
        en_d         = 1'b0;
        wren_d       = 1'b0;
        wdata_d      = '0;
        wmask_d      = '0;
        cmd_now      = cmd_done_q | (en_q & app_rdy);
        wdf_now      = wdf_done_q | (wren_q & app_wdf_rdy);

        // Round-robin search starting just past the last granted channel.
        found = 1'b0;
        gsel  = last_grant_q;
        idx   = 0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = 32'(last_grant_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && ch_req[GW'(idx)]) begin
                found = 1'b1;
                gsel  = GW'(idx);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (calib_done && found) begin
                    state_d      = CMD;
                    last_grant_d = gsel;
                    grant_id_d   = gsel;
                    we_d         = ch_we[gsel];
                    cmd_done_d   = 1'b0;
                    wdf_done_d   = 1'b0;
                    en_d         = 1'b1;
                    cmd_d        = ch_we[gsel] ? CMD_WR : CMD_RD;
                    addr_d       = ch_addr[32'(gsel)*ADDR_W +: ADDR_W];
                    if (ch_we[gsel]) begin
                        wren_d  = 1'b1;
                        wdata_d = ch_wdata[32'(gsel)*DATA_W +: DATA_W];
                        wmask_d = ch_wmask[32'(gsel)*MW +: MW];
                    end
                end
            end
            CMD: begin
                cmd_done_d = cmd_now;
                wdf_done_d = wdf_now;
                if (we_q && cmd_now && wdf_now) begin
                    state_d           = ACK;
                    ack_d[grant_id_q] = 1'b1;
                end else if (!we_q && cmd_now) begin
                    state_d = RWAIT;
                end else begin
                    // Command and write-data handshakes retire independently.
                    en_d    = ~cmd_now;
                    wren_d  = we_q & ~wdf_now;
                    cmd_d   = cmd_q;
                    addr_d  = addr_q;
                    wdata_d = wdata_q;
                    wmask_d = wmask_q;
                end
            end
            RWAIT: begin
                if (app_rd_data_valid) begin
                    state_d              = IDLE;
                    rdata_d              = app_rd_data;
                    rvalid_d[grant_id_q] = 1'b1;
                    ack_d[grant_id_q]    = 1'b1;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d           = IDLE;
                    err_d             = 1'b1;
                    ack_d[grant_id_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(NUM_CH - 1);
            grant_id_q   <= '0;
            we_q         <= 1'b0;
            cmd_done_q   <= 1'b0;
            wdf_done_q   <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            ack_q        <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
            addr_q       <= '0;
            cmd_q        <= '0;
            en_q         <= 1'b0;
            wren_q       <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            we_q         <= we_d;
            cmd_done_q   <= cmd_done_d;
            wdf_done_q   <= wdf_done_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            addr_q       <= addr_d;
            cmd_q        <= cmd_d;
            en_q         <= en_d;
            wren_q       <= wren_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
        end
    end

    assign ch_ack       = ack_q;
    assign ch_rvalid    = rvalid_q;
    assign ch_rdata     = rdata_q;
    assign app_addr     = addr_q;
    assign app_cmd      = cmd_q;
    assign app_en       = en_q;
    assign app_wdf_data = wdata_q;
    assign app_wdf_mask = wmask_q;
    assign app_wdf_wren = wren_q;
    assign app_wdf_end  = wren_q;
    assign busy         = busy_q;
    assign grant_id     = grant_id_q;
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Scoreboard bench for ddr3_port_arbiter: directed transactions against a small MIG app-port model.
module tb_ddr3_port_arbiter;
    localparam int NCH = 4;
    localparam int AW  = 27;
    localparam int DW  = 128;
    localparam int MW  = DW / 8;
    localparam logic [DW-1:0] RD_WORD    = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
    localparam logic [DW-1:0] STRAY_WORD = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;

    typedef struct { logic [AW-1:0] addr; logic [2:0] cmd; } cmd_t;
    typedef struct { logic [DW-1:0] data; logic [MW-1:0] mask; } wdf_t;
    typedef struct { logic [NCH-1:0] ack; logic [NCH-1:0] rvalid; logic [DW-1:0] rdata;
                     logic [1:0] grant; logic err; } resp_t;

    logic               clk = 1'b0;
    logic               sys_rst;
    logic               calib_done;
    logic [NCH-1:0]     ch_req, ch_we;
    logic [NCH*AW-1:0]  ch_addr;
    logic [NCH*DW-1:0]  ch_wdata;
    logic [NCH*MW-1:0]  ch_wmask;
    logic [NCH-1:0]     ch_ack, ch_rvalid;
    logic [DW-1:0]      ch_rdata;
    logic [AW-1:0]      app_addr;
    logic [2:0]         app_cmd;
    logic               app_en, app_wdf_wren, app_wdf_end;
    logic [DW-1:0]      app_wdf_data;
    logic [MW-1:0]      app_wdf_mask;
    logic               app_rdy = 1'b0;
    logic               app_wdf_rdy = 1'b0;
    logic [DW-1:0]      app_rd_data = '0;
    logic               app_rd_data_valid = 1'b0;
    logic               busy, err_timeout;
    logic [1:0]         grant_id;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cyc, wren_cyc, cmd_hs, wdf_hs, first_en;
    int rdy_delay = 0, wdf_delay = 0, rd_lat = 0;
    int en_cnt = 0, wdf_cnt = 0, rd_cnt = 0;
    bit rd_pend = 0, stray = 0;

    cmd_t  exp_cmd[$];
    wdf_t  exp_wdf[$];
    resp_t exp_resp[$];
    cmd_t  mc;
    wdf_t  mw;
    resp_t mr;

    ddr3_port_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .calib_done(calib_done),
        .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_wmask(ch_wmask),
        .ch_ack(ch_ack), .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] wdat(input int i);
        return {4{32'hC0DE0000 + 32'(i)}};
    endfunction

    task automatic set_ch(input int ch, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [MW-1:0] m);
        ch_we[2'(ch)]            = we;
        ch_addr[ch*AW +: AW]     = a;
        ch_wdata[ch*DW +: DW]    = d;
        ch_wmask[ch*MW +: MW]    = m;
    endtask

    task automatic exp_write(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [MW-1:0] m, input logic err);
        exp_cmd.push_back('{addr: a, cmd: 3'b000});
        exp_wdf.push_back('{data: d, mask: m});
        exp_resp.push_back('{ack: 4'(1 << ch), rvalid: 4'b0, rdata: '0, grant: 2'(ch), err: err});
    endtask

    task automatic exp_read(input int ch, input logic [AW-1:0] a, input logic ok,
                            input logic [DW-1:0] d, input logic err);
        exp_cmd.push_back('{addr: a, cmd: 3'b001});
        exp_resp.push_back('{ack: 4'(1 << ch), rvalid: ok ? 4'(1 << ch) : 4'b0, rdata: d,
                             grant: 2'(ch), err: err});
    endtask

    task automatic start(input logic [NCH-1:0] req, output int n0);
        @(posedge clk); #1;
        en_cyc = 0; wren_cyc = 0; cmd_hs = 0; wdf_hs = 0; first_en = -1;
        ch_req = req;
        n0 = cyc;
    endtask

    task automatic wait_ack(input int max, output int at);
        at = -1;
        for (int n = 0; n < max; n++) begin
            @(negedge clk);
            if (ch_ack != '0) begin
                at = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_ack: no ch_ack within %0d cycles", max);
    endtask

    // MIG app-port model: programmable ready delays and read-return latency.
    always @(posedge clk) begin
        #1;
        if (app_en) begin app_rdy = (en_cnt >= rdy_delay); en_cnt++; end
        else begin app_rdy = 1'b0; en_cnt = 0; end
        if (app_wdf_wren) begin app_wdf_rdy = (wdf_cnt >= wdf_delay); wdf_cnt++; end
        else begin app_wdf_rdy = 1'b0; wdf_cnt = 0; end
        if (stray) begin
            app_rd_data_valid = 1'b1; app_rd_data = STRAY_WORD; stray = 0;
        end else if (rd_pend && rd_lat > 0 && rd_cnt + 1 == rd_lat) begin
            app_rd_data_valid = 1'b1; app_rd_data = RD_WORD; rd_pend = 0;
        end else begin
            app_rd_data_valid = 1'b0;
            if (rd_pend) rd_cnt++;
        end
    end

    always @(negedge clk) begin
        if (app_en && app_rdy && app_cmd == 3'b001) begin rd_pend = 1; rd_cnt = 0; end
        if (app_en) en_cyc++;
        if (app_wdf_wren) wren_cyc++;
        if (app_en && app_rdy) cmd_hs++;
        if (app_wdf_wren && app_wdf_rdy) wdf_hs++;
        if (app_en && first_en < 0) first_en = cyc;
    end

    // Scoreboard monitor: pops an expectation whenever the DUT presents a handshake or response.
    always @(negedge clk) begin
        if (sys_rst) begin
            if (app_en && app_rdy) begin
                if (exp_cmd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cmd_unexpected: addr %0h cmd %0b", app_addr, app_cmd);
                end else begin
                    mc = exp_cmd.pop_front();
                    chk("cmd_addr", DW'(app_addr), DW'(mc.addr));
                    chk("cmd_op", DW'(app_cmd), DW'(mc.cmd));
                end
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                if (exp_wdf.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wdf_unexpected: data %0h", app_wdf_data);
                end else begin
                    mw = exp_wdf.pop_front();
                    chk("wdf_data", app_wdf_data, mw.data);
                    chk("wdf_mask", DW'(app_wdf_mask), DW'(mw.mask));
                    chk("wdf_end", DW'(app_wdf_end), DW'(1'b1));
                end
            end
            if (ch_ack != '0 || ch_rvalid != '0) begin
                if (exp_resp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL resp_unexpected: ack %b rvalid %b", ch_ack, ch_rvalid);
                end else begin
                    mr = exp_resp.pop_front();
                    chk("resp_ack", DW'(ch_ack), DW'(mr.ack));
                    chk("resp_rvalid", DW'(ch_rvalid), DW'(mr.rvalid));
                    chk("resp_grant", DW'(grant_id), DW'(mr.grant));
                    chk("resp_err", DW'(err_timeout), DW'(mr.err));
                    if (mr.rvalid != '0) chk("resp_rdata", ch_rdata, mr.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0, t;
        int at[5];
        sys_rst = 1'b0; calib_done = 1'b0; ch_req = '0; ch_we = '0;
        ch_addr = '0; ch_wdata = '0; ch_wmask = '0;
        repeat (3) @(posedge clk);
        #1 sys_rst = 1'b1;
        @(negedge clk);
        chk("rst_app_en", DW'(app_en), 0);
        chk("rst_wren", DW'(app_wdf_wren), 0);
        chk("rst_ack", DW'(ch_ack), 0);
        chk("rst_busy", DW'(busy), 0);
        chk("rst_grant", DW'(grant_id), 0);
        chk("rst_rdata", ch_rdata, 0);
        chk("rst_err", DW'(err_timeout), 0);

        // Calibration not done: requests must not be granted.
        start(4'b1111, n0);
        repeat (100) @(negedge clk);
        chk("nocalib_en_cycles", DW'(en_cyc), 0);
        chk("nocalib_busy", DW'(busy), 0);
        ch_req = '0;
        calib_done = 1'b1;

        // Single write on ch2, zero-latency handshakes.
        set_ch(2, 1'b1, 27'h0000100, wdat(2), 16'h00F0);
        exp_write(2, 27'h0000100, wdat(2), 16'h00F0, 1'b0);
        start(4'b0100, n0);
        wait_ack(20, t);
        ch_req = '0;
        chk("wr_en_lat", DW'(first_en - n0), 1);
        chk("wr_ack_lat", DW'(t - n0), 2);
        chk("wr_en_cycles", DW'(en_cyc), 1);
        chk("wr_wren_cycles", DW'(wren_cyc), 1);

        // Split handshake: command ready after 3 cycles, write data after 5.
        rdy_delay = 3; wdf_delay = 5;
        set_ch(0, 1'b1, 27'h0002000, wdat(7), 16'h8001);
        exp_write(0, 27'h0002000, wdat(7), 16'h8001, 1'b0);
        start(4'b0001, n0);
        wait_ack(30, t);
        ch_req = '0;
        rdy_delay = 0; wdf_delay = 0;
        chk("split_en_cycles", DW'(en_cyc), 4);
        chk("split_wren_cycles", DW'(wren_cyc), 6);
        chk("split_cmd_hs", DW'(cmd_hs), 1);
        chk("split_wdf_hs", DW'(wdf_hs), 1);
        chk("split_ack_lat", DW'(t - n0), 7);

        // Read on ch1, data returned 7 cycles after command accept.
        rd_lat = 7;
        set_ch(1, 1'b0, 27'h0ABCDEF, '0, '0);
        exp_read(1, 27'h0ABCDEF, 1'b1, RD_WORD, 1'b0);
        start(4'b0010, n0);
        wait_ack(30, t);
        ch_req = '0;
        chk("rd_ack_lat", DW'(t - n0), 9);

        // Read on ch3 that never returns: timeout after 16 cycles in RWAIT.
        rd_lat = 0;
        set_ch(3, 1'b0, 27'h7FFFFFF, '0, '0);
        exp_read(3, 27'h7FFFFFF, 1'b0, '0, 1'b1);
        start(4'b1000, n0);
        wait_ack(40, t);
        ch_req = '0;
        rd_pend = 0;
        chk("to_ack_lat", DW'(t - n0), 18);
        stray = 1;
        repeat (4) @(negedge clk);
        chk("stray_rdata", ch_rdata, RD_WORD);
        chk("stray_err", DW'(err_timeout), 1);
        chk("stray_busy", DW'(busy), 0);

        // Asynchronous reset in the middle of a stalled write command.
        rdy_delay = 50; wdf_delay = 50;
        set_ch(1, 1'b1, 27'h0000333, wdat(1), 16'h0002);
        start(4'b0010, n0);
        for (int i = 0; i < 10 && first_en < 0; i++) @(negedge clk);
        chk("rstmid_saw_en", DW'(first_en >= 0), 1);
        #1 sys_rst = 1'b0;
        #1;
        chk("rstmid_app_en", DW'(app_en), 0);
        chk("rstmid_wren", DW'(app_wdf_wren), 0);
        chk("rstmid_busy", DW'(busy), 0);
        chk("rstmid_grant", DW'(grant_id), 0);
        chk("rstmid_err", DW'(err_timeout), 0);
        chk("rstmid_rdata", ch_rdata, 0);
        ch_req = '0;
        rdy_delay = 0; wdf_delay = 0;
        repeat (2) @(posedge clk);
        #1 sys_rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rstrel_busy", DW'(busy), 0);
        chk("rstrel_app_en", DW'(app_en), 0);

        // Round-robin with all four channels requesting continuously.
        for (int i = 0; i < NCH; i++)
            set_ch(i, 1'b1, 27'(32'h40 + 32'(i) * 32'h10), wdat(i + 16), 16'(1 << i));
        for (int k = 0; k < 5; k++)
            exp_write(k % NCH, 27'(32'h40 + 32'(k % NCH) * 32'h10), wdat((k % NCH) + 16),
                      16'(1 << (k % NCH)), 1'b0);
        start(4'b1111, n0);
        for (int k = 0; k < 5; k++) wait_ack(20, at[k]);
        ch_req = '0;
        chk("rr_first_lat", DW'(at[0] - n0), 2);
        for (int k = 1; k < 5; k++) chk("rr_ack_spacing", DW'(at[k] - at[k-1]), 3);

        // ch3 alone, then ch0+ch3 held: ch0 next, then back to ch3.
        exp_write(3, 27'h70, wdat(19), 16'h0008, 1'b0);
        start(4'b1000, n0);
        wait_ack(20, t);
        ch_req = '0;
        exp_write(0, 27'h40, wdat(16), 16'h0001, 1'b0);
        exp_write(3, 27'h70, wdat(19), 16'h0008, 1'b0);
        start(4'b1001, n0);
        wait_ack(20, t);
        wait_ack(20, t);
        ch_req = '0;

        repeat (5) @(negedge clk);
        chk("sb_cmd_drained", DW'(exp_cmd.size()), 0);
        chk("sb_wdf_drained", DW'(exp_wdf.size()), 0);
        chk("sb_resp_drained", DW'(exp_resp.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr3_port_arbiter.md
# ddr3_port_arbiter

N-channel round-robin arbiter that shares the single DDR3 controller user (app) interface inside the SNES block design among several memory clients (CPU/PPU/APU/DMA bridges). It issues exactly one command at a time and returns read data to the granted channel. A read-timeout watchdog flags a stalled controller. Sits between the client bridges and the MIG app port, in the controller's UI clock domain.

## Interface
- NUM_CH, 4, number of client channels (2..8)
- ADDR_W, 27, app address width
- DATA_W, 128, app data width; mask width is DATA_W/8
- TIMEOUT_CYC, 1023, max cycles waiting for read data before timeout (≥1)
- sys_clk  in  1  UI clock; all logic rising-edge
- sys_rst  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- calib_done  in  1  controller init_calib_complete; gates new grants
- ch_req  in  NUM_CH  per-channel request; held until ch_ack
- ch_we  in  NUM_CH  1 = write, 0 = read
- ch_addr  in  NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
- ch_wdata  in  NUM_CH*DATA_W  packed write data
- ch_wmask  in  NUM_CH*DATA_W/8  packed byte masks (1 = byte not written)
- ch_ack  out  NUM_CH  one-cycle completion pulse
- ch_rvalid  out  NUM_CH  one-cycle read-data-valid pulse, coincident with ch_ack on good reads
- ch_rdata  out  DATA_W  shared read data, valid when any ch_rvalid bit set
- app_addr / app_cmd / app_en  out  ADDR_W / 3 / 1  command port; app_cmd 3'b000 write, 3'b001 read
- app_rdy  in  1  command accepted when app_en & app_rdy
- app_wdf_data / app_wdf_mask  out  DATA_W / DATA_W/8  write data
- app_wdf_wren / app_wdf_end  out  1 / 1  always asserted together (single-beat)
- app_wdf_rdy  in  1  write data accepted when app_wdf_wren & app_wdf_rdy
- app_rd_data  in  DATA_W ; app_rd_data_valid  in  1  read return
- busy  out  1  high in any state other than IDLE
- grant_id  out  $clog2(NUM_CH)  currently/last granted channel
- err_timeout  out  1  sticky read-timeout flag

## Operation
- States: IDLE, CMD, RWAIT, ACK.
- IDLE: if calib_done and |ch_req, grant first requesting channel searching from (last_grant+1) mod NUM_CH upward with wrap; latch addr/we/wdata/wmask of that channel; grant_id, last_grant ← g; → CMD. Otherwise stay.
- CMD: app_en high until app_rdy seen (cmd_done). Write: app_wdf_wren/end high until app_wdf_rdy seen (wdf_done); command and data handshakes independent, either order or same cycle. Write → ACK when both done (including the cycle the last completes). Read → RWAIT on cmd_done, timeout counter cleared.
- RWAIT: on app_rd_data_valid, register app_rd_data into ch_rdata, pulse ch_rvalid[g] and ch_ack[g], → IDLE. Counter increments each cycle; on reaching TIMEOUT_CYC without data: set err_timeout, pulse ch_ack[g] with ch_rvalid low, → IDLE.
- ACK: pulse ch_ack[g]; → IDLE.
- app_rd_data_valid outside RWAIT (stray/late after timeout): ignored, no output change.
- calib_done falling: blocks only new grants; in-flight transaction completes.
- Requester still asserting ch_req the cycle after ch_ack: new request, arbitrated normally (round-robin moves past it if others wait).

## Timing
- Reset (async assert, sync-released by upstream): state IDLE, last_grant = NUM_CH-1 (ch0 wins first), grant_id 0, all outputs 0, ch_rdata 0, err_timeout 0, counter 0.
- Request seen in IDLE at cycle t → app_en (and wdf_wren for writes) high at t+1.
- Write with app_rdy and app_wdf_rdy high at t+1 → ch_ack at t+2; each stall cycle adds one.
- Read: app_rd_data_valid at cycle r → ch_rdata/ch_rvalid/ch_ack at r+1.
- Back-to-back: next grant earliest the cycle after ch_ack (IDLE one cycle); write throughput 1 per 3 cycles.
- Timeout: ch_ack with err_timeout rising exactly TIMEOUT_CYC cycles after entering RWAIT.
- All outputs registered; app_* driven only in CMD, zero elsewhere.

## Test plan
- Reset/idle: sys_rst low mid-CMD → all outputs 0 immediately, IDLE after release; calib_done=0 with ch_req=4'b1111 → no app_en for 100 cycles.
- Single write ch2, addr 0x0000100, app_rdy/app_wdf_rdy high → app_en/app_cmd=000/app_wdf_wren at t+1, ch_ack=4'b0100 at t+2.
- Split handshake: write with app_rdy delayed 3 cycles, app_wdf_rdy delayed 5 → app_en drops after its accept, wren held to cycle 5, ch_ack next cycle, exactly one of each handshake.
- Read ch1 with data 0xDEADBEEF… returned 7 cycles after accept → ch_rdata matches, ch_rvalid=ch_ack=4'b0010 one cycle.
- Round-robin: ch_req=4'b1111 held continuously with zero-latency model → grant order 0,1,2,3,0 ; ch3 alone then ch0+ch3 → ch0 next.
- Timeout: TIMEOUT_CYC=16, read never returns → ch_ack with ch_rvalid=0 at 16 cycles, err_timeout stays 1; late app_rd_data_valid ignored.
